// File: rtl/lbg_pkg.sv
// Shared LBG types: codebook geometry, split-writer FSM states, word/address types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbg_pkg;

    localparam int MFCC_DIM = 13;   // elements per codeword
    localparam int CW_MAX   = 16;   // largest codebook held in the RAM
    localparam int WORD_W   = 14;   // default codeword element width
    localparam int ADDR_W   = 8;    // default codebook RAM address width

    typedef logic signed [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic [2:0]               cw_idx_t;   // source codeword index k (0..CW_MAX/2-1)
    typedef logic [3:0]               dim_idx_t;  // element index d (0..MFCC_DIM-1)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WP,
        ST_WM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lbg_split_perturb.sv
// Split perturbation of one codeword element: y -> {y + y*eps, y - y*eps}, eps = 2^-EPS_SHIFT.
// Latency: combinational.
// Backpressure: none.
// Ports: y (signed element in), y_plus / y_minus (perturbed elements out).
// Option LBG_SPLIT_SAT_EN: saturate results to the DW-bit signed range instead of wrapping.
module lbg_split_perturb
    import lbg_pkg::*;
#(
    parameter int DW        = WORD_W,
    parameter int EPS_SHIFT = 4
) (
    input  logic signed [DW-1:0] y,
    output logic signed [DW-1:0] y_plus,
    output logic signed [DW-1:0] y_minus
);

    // Arithmetic shift keeps the sign, so negative elements round toward -inf.
    logic signed [DW-1:0] eps;
    assign eps = y >>> EPS_SHIFT;

`ifdef LBG_SPLIT_SAT_EN
    localparam logic [DW-1:0] W_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] W_MIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [DW:0] sum_w;
    logic signed [DW:0] dif_w;

    assign sum_w = {y[DW-1], y} + {eps[DW-1], eps};
    assign dif_w = {y[DW-1], y} - {eps[DW-1], eps};

    // Top two bits disagree exactly when the DW+1 result left the DW-bit range.
    always_comb begin
        y_plus  = sum_w[DW-1:0];
        y_minus = dif_w[DW-1:0];
        if (sum_w[DW] != sum_w[DW-1]) y_plus  = sum_w[DW] ? W_MIN : W_MAX;
        if (dif_w[DW] != dif_w[DW-1]) y_minus = dif_w[DW] ? W_MIN : W_MAX;
    end
`else
    // Wrap mode: the DW-bit sum is the DW+1-bit result with its top bit dropped.
    assign y_plus  = y + eps;
    assign y_minus = y - eps;
`endif

endmodule

// File: rtl/lbg_codebook_split.sv
// LBG split writer: reads 2^(CNT_FOR-1) codewords, writes 2^CNT_FOR perturbed codewords (y+, y-).
// Latency: one element per 3 cycles; START->FINSH = 3*13*2^(CNT_FOR-1)+2 cycles.
// Backpressure: none; source RAM has fixed 1-cycle read latency, destination accepts every strobe.
// Ports: clk, rst_n (async active-low), START/Clear/CNT_FOR control, FINSH done pulse,
//        SRC_rd_addr/SRC_rd_data source RAM, LBG_SPLIT_wr_addr/_wr_data/_wr_en destination RAM.
// Option LBG_SPLIT_SAT_EN (in lbg_split_perturb): saturating instead of wrapping y+/y-.
module lbg_codebook_split
    import lbg_pkg::*;
#(
    parameter int EPS_SHIFT = 4,
    parameter int DW        = 14,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          START,
    input  logic          Clear,
    input  logic [2:0]    CNT_FOR,
    output logic          FINSH,
    output logic [AW-1:0] SRC_rd_addr,
    input  logic [DW-1:0] SRC_rd_data,
    output logic [AW-1:0] LBG_SPLIT_wr_addr,
    output logic [DW-1:0] LBG_SPLIT_wr_data,
    output logic          LBG_SPLIT_wr_en
);

    state_t          state_q, state_d;
    cw_idx_t         k_q;
    cw_idx_t         last_k_q;
    dim_idx_t        d_q;
    logic [DW-1:0]   y_q;
    logic [AW-1:0]   src_addr_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q;
    logic            wr_en_q;
    logic            finsh_q;

    logic            cnt_ok;
    cw_idx_t         last_k_d;
    logic            last_elem;
    logic [AW-1:0]   wr_base;
    logic [DW-1:0]   pert_in;
    logic [DW-1:0]   y_plus;
    logic [DW-1:0]   y_minus;

    assign cnt_ok    = (CNT_FOR != 3'd0) && (CNT_FOR <= 3'd4);
    assign last_elem = (k_q == last_k_q) && (d_q == dim_idx_t'(MFCC_DIM - 1));

    // Index of the last source codeword: 2^(CNT_FOR-1) - 1.
    always_comb begin
        last_k_d = 3'd0;
        case (CNT_FOR)
            3'd2:    last_k_d = 3'd1;
            3'd3:    last_k_d = 3'd3;
            3'd4:    last_k_d = 3'd7;
            default: last_k_d = 3'd0;
        endcase
    end

    // Destination codeword 2k starts at 26k; codeword 2k+1 follows 13 words later.
    assign wr_base = AW'(k_q) * AW'(2 * MFCC_DIM) + AW'(d_q);

    // One perturb unit shared: y+ from live RAM data in WP, y- from the held copy in WM.
    assign pert_in = (state_q == ST_WP) ? SRC_rd_data : y_q;

    lbg_split_perturb #(
        .DW        (DW),
        .EPS_SHIFT (EPS_SHIFT)
    ) u_perturb (
        .y       (pert_in),
        .y_plus  (y_plus),
        .y_minus (y_minus)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (START) state_d = cnt_ok ? ST_RD : ST_DONE;
                ST_RD:   state_d = ST_WP;
                ST_WP:   state_d = ST_WM;
                ST_WM:   state_d = last_elem ? ST_DONE : ST_RD;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            last_k_q   <= '0;
            d_q        <= '0;
            y_q        <= '0;
            src_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            finsh_q    <= 1'b0;
        end else if (Clear) begin
            k_q        <= '0;
            last_k_q   <= '0;
            d_q        <= '0;
            y_q        <= '0;
            src_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            finsh_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            finsh_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Address is presented during RD so the data lands in WP.
                    if (START && cnt_ok) begin
                        k_q        <= '0;
                        d_q        <= '0;
                        last_k_q   <= last_k_d;
                        src_addr_q <= '0;
                    end
                end
                ST_WP: begin
                    y_q       <= SRC_rd_data;
                    wr_addr_q <= wr_base;
                    wr_data_q <= y_plus;
                    wr_en_q   <= 1'b1;
                end
                ST_WM: begin
                    wr_addr_q  <= wr_base + AW'(MFCC_DIM);
                    wr_data_q  <= y_minus;
                    wr_en_q    <= 1'b1;
                    // Source words are contiguous (k*13+d), so the read address just counts.
                    src_addr_q <= src_addr_q + AW'(1);
                    if (d_q == dim_idx_t'(MFCC_DIM - 1)) begin
                        d_q <= '0;
                        k_q <= k_q + 3'd1;
                    end else begin
                        d_q <= d_q + 4'd1;
                    end
                end
                ST_DONE: finsh_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign FINSH             = finsh_q;
    assign SRC_rd_addr       = src_addr_q;
    assign LBG_SPLIT_wr_addr = wr_addr_q;
    assign LBG_SPLIT_wr_data = wr_data_q;
    assign LBG_SPLIT_wr_en   = wr_en_q;

endmodule
